instruction_legality_stage: RTL and testbench

//  F/D boundary stage. Registers the fetched instruction through a 2-entry skid buffer with valid/ready handshake.

---
 rtl/instruction_legality_stage_pkg.sv | 79 +++++++
 rtl/instruction_legality_decode.sv | 111 +++++++++++
 rtl/instruction_legality_stage.sv | 132 +++++++++++++
 tb/tb_instruction_legality_stage.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_legality_stage_pkg.sv
// Shared ISA constants and entry bundle for the F/D legality stage.
// Opcode, funct, rt/rs selector codes and ExcCode values.
package instruction_legality_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;
  localparam logic [5:0] FN_ERET  = 6'h18;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [4:0] RS_MF = 5'h00;
  localparam logic [4:0] RS_MT = 5'h04;

  localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
  localparam logic [4:0] EXC_CODE_RI   = 5'd10;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bd;
    logic        exc;
    logic [4:0]  exccode;
    logic        ri;
  } entry_t;

endpackage

// File: rtl/instruction_legality_decode.sv
// Combinational legality check of one word against the MIPS subset.
// Group enables and optional reserved-field-must-be-zero checking.
module instruction_legality_decode
  import instruction_legality_stage_pkg::*;
#(
  parameter bit EN_MULDIV  = 1'b1,
  parameter bit EN_COP0    = 1'b1,
  parameter bit EN_PARTIAL = 1'b1,
  parameter bit STRICT     = 1'b0
) (
  input  logic [31:0] instr,
  output logic        legal
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] sh;
  logic       ok;
  logic       zok;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign sh = instr[10:6];
  assign fn = instr[5:0];

  // Supported-word match (ok) and reserved-field cleanliness (zok).
  always_comb begin
    ok  = 1'b0;
    zok = 1'b1;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA: begin
            ok  = 1'b1;
            zok = (rs == 5'd0);
          end
          FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU: begin
            ok  = 1'b1;
            zok = (sh == 5'd0);
          end
          FN_JR: begin
            ok  = 1'b1;
            zok = (rt == 5'd0) && (rd == 5'd0)
                  && (sh == 5'd0);
          end
          FN_JALR: begin
            ok  = 1'b1;
            zok = (rt == 5'd0) && (sh == 5'd0);
          end
          FN_MFHI, FN_MFLO: begin
            ok  = EN_MULDIV;
            zok = (rs == 5'd0) && (rt == 5'd0)
                  && (sh == 5'd0);
          end
          FN_MTHI, FN_MTLO: begin
            ok  = EN_MULDIV;
            zok = (rt == 5'd0) && (rd == 5'd0)
                  && (sh == 5'd0);
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            ok  = EN_MULDIV;
            zok = (rd == 5'd0) && (sh == 5'd0);
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ,
          RT_BLTZAL, RT_BGEZAL: ok = 1'b1;
          default: ;
        endcase
      end
      OP_COP0: begin
        if (instr[25]) begin
          ok  = EN_COP0 && (fn == FN_ERET);
          zok = (instr[24:6] == 19'd0);
        end else if (rs == RS_MF || rs == RS_MT) begin
          ok  = EN_COP0;
          zok = (instr[10:3] == 8'd0);
        end
      end
      OP_LB, OP_LH, OP_LBU, OP_LHU,
      OP_SB, OP_SH: ok = EN_PARTIAL;
      OP_BLEZ, OP_BGTZ: begin
        ok  = 1'b1;
        zok = (rt == 5'd0);
      end
      OP_LUI: begin
        ok  = 1'b1;
        zok = (rs == 5'd0);
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI,
      OP_LW, OP_SW: ok = 1'b1;
      default: ;
    endcase
  end

  assign legal = ok & (~STRICT | zok);

endmodule

// File: rtl/instruction_legality_stage.sv
// F/D boundary: 2-entry skid buffer, RI tagging, illegal counter.
// Main entry drives the outputs; skid catches one word under stall.
module instruction_legality_stage
  import instruction_legality_stage_pkg::*;
#(
  parameter bit          EN_MULDIV  = 1'b1,
  parameter bit          EN_COP0    = 1'b1,
  parameter bit          EN_PARTIAL = 1'b1,
  parameter bit          STRICT     = 1'b0,
  parameter logic [4:0]  EXC_RI     = EXC_CODE_RI,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             in_bd,
  input  logic             in_exc,
  input  logic [4:0]       in_exccode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             out_bd,
  output logic             out_exc,
  output logic [4:0]       out_exccode,
  output logic [CNT_W-1:0] ill_count,
  input  logic             ill_clear
);

  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           new_e;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             legal;
  logic             acc;
  logic             deq;

  instruction_legality_decode #(
    .EN_MULDIV  (EN_MULDIV),
    .EN_COP0    (EN_COP0),
    .EN_PARTIAL (EN_PARTIAL),
    .STRICT     (STRICT)
  ) u_decode (
    .instr (in_instr),
    .legal (legal)
  );

  assign acc = in_valid & ~skid_v_q & ~flush;
  assign deq = main_v_q & out_ready;

  // Classify the incoming word; upstream exception has priority.
  always_comb begin
    new_e         = '0;
    new_e.ri      = ~in_exc & ~legal;
    new_e.exc     = in_exc | ~legal;
    new_e.exccode = in_exc ? in_exccode : EXC_RI;
    new_e.instr   = new_e.exc ? 32'h0 : in_instr;
    new_e.pc      = in_pc;
    new_e.bd      = in_bd;
  end

  // Skid buffer next state: flush empties, skid refills main on pop.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (deq) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = acc;
        if (acc) main_d = new_e;
      end
    end else if (main_v_q) begin
      if (acc) begin
        skid_d   = new_e;
        skid_v_d = 1'b1;
      end
    end else begin
      main_v_d = acc;
      if (acc) main_d = new_e;
    end
  end

  // Saturating RI counter; clear beats a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (ill_clear) begin
      cnt_d = '0;
    end else if (deq && main_q.ri && ~&cnt_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready    = ~skid_v_q;
  assign out_valid   = main_v_q;
  assign out_instr   = main_q.instr;
  assign out_pc      = main_q.pc;
  assign out_bd      = main_q.bd;
  assign out_exc     = main_q.exc;
  assign out_exccode = main_q.exccode;
  assign ill_count   = cnt_q;

endmodule

// File: tb/tb_instruction_legality_stage.sv
// Directed + random bench: default instance and a strict/no-muldiv/2-bit-counter one.
// Queue-based reference model with table-driven ISA legality.
module tb_instruction_legality_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_bd;
  logic        in_exc;
  logic [4:0]  in_exccode;
  logic        out_ready;
  logic        ill_clear;

  logic        d_in_ready, d_out_valid, d_out_bd, d_out_exc;
  logic [31:0] d_out_instr, d_out_pc;
  logic [4:0]  d_out_exccode;
  logic [15:0] d_ill_count;
  logic        s_in_ready, s_out_valid, s_out_bd, s_out_exc;
  logic [31:0] s_out_instr, s_out_pc;
  logic [4:0]  s_out_exccode;
  logic [1:0]  s_ill_count;

  always #5 clk = ~clk;

  instruction_legality_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(d_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_bd(in_bd),
    .in_exc(in_exc), .in_exccode(in_exccode),
    .out_valid(d_out_valid), .out_ready(out_ready),
    .out_instr(d_out_instr), .out_pc(d_out_pc),
    .out_bd(d_out_bd), .out_exc(d_out_exc),
    .out_exccode(d_out_exccode),
    .ill_count(d_ill_count), .ill_clear(ill_clear)
  );

  instruction_legality_stage #(
    .EN_MULDIV(1'b0), .STRICT(1'b1), .CNT_W(2)
  ) dut_s (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_bd(in_bd),
    .in_exc(in_exc), .in_exccode(in_exccode),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_instr(s_out_instr), .out_pc(s_out_pc),
    .out_bd(s_out_bd), .out_exc(s_out_exc),
    .out_exccode(s_out_exccode),
    .ill_count(s_ill_count), .ill_clear(ill_clear)
  );

  localparam logic [31:0] RS = 32'h03E00000;
  localparam logic [31:0] RT = 32'h001F0000;
  localparam logic [31:0] RD = 32'h0000F800;
  localparam logic [31:0] SH = 32'h000007C0;

  // SPECIAL functs; indices 8..15 are the mul/div group
  localparam logic [5:0] SP_FN [26] = '{
    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
    6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b,
    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
    6'h2a, 6'h2b};
  localparam logic [31:0] SP_ZM [26] = '{
    RS, RS, RS, SH, SH, SH, RT|RD|SH, RT|SH,
    RS|RT|SH, RT|RD|SH, RS|RT|SH, RT|RD|SH,
    RD|SH, RD|SH, RD|SH, RD|SH,
    SH, SH, SH, SH, SH, SH, SH, SH, SH, SH};
  localparam logic [5:0] OPS [22] = '{
    6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
    6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
    6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b};
  localparam logic [31:0] OP_ZM [22] = '{
    0, 0, 0, 0, RT, RT, 0, 0, 0, 0, 0, 0, 0, RS,
    0, 0, 0, 0, 0, 0, 0, 0};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bd;
    logic        exc;
    logic [4:0]  code;
    logic        ri;
  } exp_t;

  exp_t qd[$];
  exp_t qs[$];
  int   cd = 0;
  int   cs = 0;
  int   total = 0;
  int   bad = 0;

  function automatic bit legal_m(logic [31:0] w, bit md, bit strict);
    logic [5:0]  op = w[31:26];
    logic [5:0]  fn = w[5:0];
    logic [4:0]  rt = w[20:16];
    bit          hit = 1'b0;
    logic [31:0] zm = '0;
    if (op == 6'h00) begin
      for (int i = 0; i < 26; i++)
        if (fn == SP_FN[i]) begin
          hit = md || i < 8 || i > 15;
          zm  = SP_ZM[i];
        end
    end else if (op == 6'h01) begin
      hit = rt inside {5'd0, 5'd1, 5'd16, 5'd17};
    end else if (op == 6'h10) begin
      if ((w & 32'hFE00003F) == 32'h42000018) begin
        hit = 1'b1;
        zm  = 32'h01FFFFC0;
      end else if ((w & 32'hFFE00000) == 32'h40000000 ||
                   (w & 32'hFFE00000) == 32'h40800000) begin
        hit = 1'b1;
        zm  = 32'h000007F8;
      end
    end else begin
      for (int i = 0; i < 22; i++)
        if (op == OPS[i]) begin
          hit = 1'b1;
          zm  = OP_ZM[i];
        end
    end
    return hit && (!strict || (w & zm) == 32'h0);
  endfunction

  function automatic exp_t mk(bit lg);
    exp_t e;
    e.ri    = !in_exc && !lg;
    e.exc   = in_exc || !lg;
    e.code  = in_exc ? in_exccode : 5'd10;
    e.instr = e.exc ? 32'h0 : in_instr;
    e.pc    = in_pc;
    e.bd    = in_bd;
    return e;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] w = $urandom;
    int          i;
    int          sel = $urandom_range(0, 4);
    case (sel)
      1: begin
        i = $urandom_range(0, 25);
        w[31:26] = 6'h00;
        w[5:0] = SP_FN[i];
        if ($urandom_range(0, 1) == 1) w = w & ~SP_ZM[i];
      end
      2: begin
        i = $urandom_range(0, 21);
        w[31:26] = OPS[i];
        if ($urandom_range(0, 1) == 1) w = w & ~OP_ZM[i];
      end
      3: begin
        w[31:26] = 6'h01;
        if ($urandom_range(0, 1) == 1) w[19:17] = 3'b000;
      end
      4: begin
        i = $urandom_range(0, 2);
        if (i == 0) w = 32'h42000018;
        else if (i == 1) w = {11'h200, w[20:11], 8'h0, w[2:0]};
        else w = {11'h204, w[20:0]};
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("d_valid", d_out_valid, qd.size() > 0);
    chk("d_ready", d_in_ready, qd.size() < 2);
    chk("d_cnt", d_ill_count, cd);
    chk("s_valid", s_out_valid, qs.size() > 0);
    chk("s_ready", s_in_ready, qs.size() < 2);
    chk("s_cnt", s_ill_count, cs);
    if (qd.size() > 0)
      chk("d_entry",
          {d_out_instr, d_out_pc, d_out_bd, d_out_exc, d_out_exccode},
          {qd[0].instr, qd[0].pc, qd[0].bd, qd[0].exc, qd[0].code});
    if (qs.size() > 0)
      chk("s_entry",
          {s_out_instr, s_out_pc, s_out_bd, s_out_exc, s_out_exccode},
          {qs[0].instr, qs[0].pc, qs[0].bd, qs[0].exc, qs[0].code});
  endtask

  // called at negedge: check, advance model over next posedge
  task automatic tick();
    bit   acc;
    bit   deq;
    exp_t ed;
    exp_t es;
    check_outs();
    acc = in_valid && qd.size() < 2 && !flush;
    deq = qd.size() > 0 && out_ready;
    ed = mk(legal_m(in_instr, 1'b1, 1'b0));
    es = mk(legal_m(in_instr, 1'b0, 1'b1));
    if (deq) begin
      if (qd[0].ri && cd < 65535) cd++;
      if (qs[0].ri && cs < 3) cs++;
      void'(qd.pop_front());
      void'(qs.pop_front());
    end
    if (ill_clear) begin
      cd = 0;
      cs = 0;
    end
    if (flush) begin
      qd.delete();
      qs.delete();
    end else if (acc) begin
      qd.push_back(ed);
      qs.push_back(es);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_word(logic [31:0] w, logic [31:0] pc);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    in_pc = pc;
    for (int k = 0; k < 16; k++) begin
      ok = qd.size() < 2 && !flush;
      tick();
      if (ok) break;
    end
    if (!ok) begin
      total++;
      bad++;
      $error("FAIL push_timeout observed=stuck expected=accepted");
    end
    in_valid = 1'b0;
  endtask

  localparam logic [31:0] STREAM [6] = '{
    32'h00221821, 32'h34220005, 32'h8C220004,
    32'hAC220004, 32'h10220003, 32'h42000018};

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_pc = '0; in_bd = 1'b0;
    in_exc = 1'b0; in_exccode = '0;
    out_ready = 1'b0; ill_clear = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready_valid", {d_in_ready, d_out_valid}, 2'b10);
    chk("rst_outs",
        {d_out_instr, d_out_pc, d_out_bd, d_out_exc,
         d_out_exccode, d_ill_count}, 0);
    reset = 1'b0;

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_instr = STREAM[i];
      in_pc = 32'h1000 + 32'(4 * i);
      in_bd = (i == 5);
      tick();
      if (i == 0) chk("lat1", {d_out_valid, d_out_pc}, {1'b1, 32'h1000});
    end
    in_valid = 1'b0;
    in_bd = 1'b0;
    tick();
    tick();

    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFC000000; in_pc = 32'h3000;
    tick();
    in_valid = 1'b0;
    chk("ri_tag", {d_out_exc, d_out_exccode, d_out_instr, d_out_pc},
        {1'b1, 5'd10, 32'h0, 32'h3000});
    out_ready = 1'b1;
    tick();
    chk("ri_cnt", d_ill_count, 16'd1);

    in_valid = 1'b1; in_instr = 32'h00850018;
    tick();
    in_valid = 1'b0;
    chk("mult_en_exc", {d_out_exc, s_out_exc, s_out_exccode}, {1'b0, 1'b1, 5'd10});
    tick();
    in_valid = 1'b1; in_instr = 32'h00A41060;
    tick();
    in_valid = 1'b0;
    chk("add_shamt_exc", {d_out_exc, s_out_exc}, 2'b01);
    tick();

    in_valid = 1'b1; in_instr = 32'hFC000000;
    in_exc = 1'b1; in_exccode = 5'd4;
    tick();
    in_valid = 1'b0; in_exc = 1'b0;
    chk("up_exc_code", {d_out_exc, d_out_exccode, s_out_exccode},
        {1'b1, 5'd4, 5'd4});
    tick();
    chk("up_exc_nocnt", d_ill_count, 16'd1);

    out_ready = 1'b0;
    push_word(32'h24010001, 32'h4000);
    push_word(32'h24010002, 32'h4004);
    chk("bp_full", {d_in_ready, d_out_valid, d_out_pc}, {1'b0, 1'b1, 32'h4000});
    out_ready = 1'b1;
    push_word(32'h24010003, 32'h4008);
    for (int k = 0; k < 3; k++) tick();

    out_ready = 1'b0;
    push_word(32'h24010004, 32'h5000);
    push_word(32'h24010005, 32'h5004);
    in_valid = 1'b1; in_instr = 32'h24010006; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_empty", {d_out_valid, d_in_ready}, 2'b01);
    tick();

    ill_clear = 1'b1;
    tick();
    ill_clear = 1'b0;
    chk("clear", {d_ill_count, s_ill_count}, 18'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) push_word(32'hFC000000, 32'h6000 + 32'(4 * k));
    tick();
    tick();
    chk("sat_cnt", {d_ill_count, s_ill_count}, {16'd5, 2'd3});

    out_ready = 1'b0;
    push_word(32'hFC000000, 32'h7000);
    ill_clear = 1'b1; out_ready = 1'b1;
    tick();
    ill_clear = 1'b0;
    chk("clear_wins", {d_ill_count, s_ill_count}, 18'd0);

    for (int k = 0; k < 400; k++) begin
      in_valid   = $urandom_range(0, 3) != 0;
      out_ready  = $urandom_range(0, 2) != 0;
      flush      = $urandom_range(0, 39) == 0;
      ill_clear  = $urandom_range(0, 59) == 0;
      in_exc     = $urandom_range(0, 9) == 0;
      in_exccode = 5'($urandom);
      in_bd      = 1'($urandom);
      in_pc      = $urandom & 32'hFFFFFFFC;
      in_instr   = gen();
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; ill_clear = 1'b0;
    in_exc = 1'b0; out_ready = 1'b0;

    push_word(32'hFC000000, 32'h8000);
    push_word(32'h24010007, 32'h8004);
    reset = 1'b1;
    #1;
    chk("async_rst", {d_out_valid, d_in_ready, d_ill_count, s_ill_count},
        {1'b0, 1'b1, 16'd0, 2'd0});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    qd.delete();
    qs.delete();
    cd = 0;
    cs = 0;
    tick();
    out_ready = 1'b1;
    push_word(32'h00221821, 32'h9000);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
